ssp_rx_shifter: RTL

Slave-side serial receiver for the SSP block. It takes the externally supplied serial clock, frame pulse and data (SSPCLKIN, SSPFSSIN, SSPRXD) in TI synchronous serial format, and deserialises 8-bit MSB-first frames in the PCLK domain. Each frame lands in a one-entry holding register and is offered to the receive FIFO with a valid/ready handshake. It is the receiving counterpart of the serial clock generator on the transmit side.

---
 rtl/ssp_pkg.sv | 21 ++
 rtl/ssp_in_sync.sv | 85 ++++++++
 rtl/ssp_rx_shifter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ssp_pkg.sv
// ---------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the SSP receive path: frame width, bit-counter
// width, receive state type and a helper for end-of-frame detection.
// ---------------------------------------------------------------------------
package ssp_pkg;

  localparam int unsigned SSP_FRAME_W = 8;
  localparam int unsigned SSP_CNT_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  // True when the bit counter points at the last (LSB) bit of a frame.
  function automatic logic cnt_is_last(input logic [SSP_CNT_W-1:0] cnt);
    return cnt == SSP_CNT_W'(SSP_FRAME_W - 1);
  endfunction

endpackage

// File: rtl/ssp_in_sync.sv
// ---------------------------------------------------------------------------
// ssp_in_sync
// Input capture and sample-event detection for the SSP slave receiver.
// A sample event is a falling edge of the captured serial clock; the
// frame sync and data captured alongside it are presented with the strobe.
//
// Configuration macro: SSP_RX_SYNC_EN
//   defined   : 2-flop synchronizer per input plus one clock delay flop
//   undefined : single capture register plus one clock delay flop
//
// Ports
//   i_clk     in   system clock (PCLK)
//   i_rst_n   in   asynchronous active-low reset
//   i_sclk    in   external serial clock
//   i_fss     in   external frame sync
//   i_rxd     in   external serial data
//   o_sample  out  one-cycle strobe: captured serial clock fell
//   o_fss     out  frame sync aligned with o_sample
//   o_rxd     out  serial data aligned with o_sample
// ---------------------------------------------------------------------------
module ssp_in_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_fss,
  input  logic i_rxd,
  output logic o_sample,
  output logic o_fss,
  output logic o_rxd
);

  logic w_sclk;
  logic r_sclk_d;

`ifdef SSP_RX_SYNC_EN
  logic [1:0] r_sclk_sync;
  logic [1:0] r_fss_sync;
  logic [1:0] r_rxd_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= '0;
      r_fss_sync  <= '0;
      r_rxd_sync  <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], i_sclk};
      r_fss_sync  <= {r_fss_sync[0],  i_fss};
      r_rxd_sync  <= {r_rxd_sync[0],  i_rxd};
      r_sclk_d    <= r_sclk_sync[1];
    end
  end

  assign w_sclk = r_sclk_sync[1];
  assign o_fss  = r_fss_sync[1];
  assign o_rxd  = r_rxd_sync[1];
`else
  logic r_sclk_q;
  logic r_fss_q;
  logic r_rxd_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_q <= 1'b0;
      r_fss_q  <= 1'b0;
      r_rxd_q  <= 1'b0;
      r_sclk_d <= 1'b0;
    end else begin
      r_sclk_q <= i_sclk;
      r_fss_q  <= i_fss;
      r_rxd_q  <= i_rxd;
      r_sclk_d <= r_sclk_q;
    end
  end

  assign w_sclk = r_sclk_q;
  assign o_fss  = r_fss_q;
  assign o_rxd  = r_rxd_q;
`endif

  // Data and sync travel through the same number of flops as the clock,
  // so they are aligned with the strobe without extra staging.
  assign o_sample = r_sclk_d & ~w_sclk;

endmodule

// File: rtl/ssp_rx_shifter.sv
// ---------------------------------------------------------------------------
// ssp_rx_shifter
// Slave-side SSP receiver (TI synchronous serial format). Deserialises
// 8-bit MSB-first frames in the PCLK domain into a one-entry holding
// register offered downstream with a valid/ready handshake.
//
// Configuration macro: SSP_RX_SYNC_EN (see ssp_in_sync)
//
// Ports
//   PCLK          in   system clock
//   CLEAR_B       in   asynchronous active-low reset
//   SSPCLKIN      in   serial clock from external master
//   SSPFSSIN      in   frame sync, one serial period before the MSB
//   SSPRXD        in   serial data, MSB first
//   RX_READY      in   consumer accepts RXDATA this cycle
//   RXDATA        out  received frame, stable while RX_VALID=1
//   RX_VALID      out  RXDATA holds an unconsumed frame
//   RX_BUSY       out  frame in progress
//   RX_OVERRUN    out  one-cycle pulse: completed frame dropped
//   RX_FRAME_ERR  out  one-cycle pulse: frame sync arrived mid-frame
// ---------------------------------------------------------------------------
module ssp_rx_shifter
  import ssp_pkg::*;
(
  input  logic                   PCLK,
  input  logic                   CLEAR_B,
  input  logic                   SSPCLKIN,
  input  logic                   SSPFSSIN,
  input  logic                   SSPRXD,
  input  logic                   RX_READY,
  output logic [SSP_FRAME_W-1:0] RXDATA,
  output logic                   RX_VALID,
  output logic                   RX_BUSY,
  output logic                   RX_OVERRUN,
  output logic                   RX_FRAME_ERR
);

  logic w_sample;
  logic w_fss;
  logic w_rxd;

  rx_state_e              r_state;
  logic [SSP_CNT_W-1:0]   r_cnt;
  // Only the first seven bits need storing; the eighth is taken directly
  // from the input at the completing sample event.
  logic [SSP_FRAME_W-2:0] r_shift;
  logic [SSP_FRAME_W-1:0] r_rxdata;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_frame_err;

  ssp_in_sync u_in_sync (
    .i_clk    (PCLK),
    .i_rst_n  (CLEAR_B),
    .i_sclk   (SSPCLKIN),
    .i_fss    (SSPFSSIN),
    .i_rxd    (SSPRXD),
    .o_sample (w_sample),
    .o_fss    (w_fss),
    .o_rxd    (w_rxd)
  );

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rxdata    <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;

      // Transfer drains the holding register; a frame completing in the
      // same cycle overrides this below and keeps it full.
      if (r_valid && RX_READY) begin
        r_valid <= 1'b0;
      end

      if (w_sample) begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_fss) begin
              r_state <= ST_SHIFT;
              r_cnt   <= '0;
              r_shift <= '0;
            end
          end

          ST_SHIFT: begin
            if (cnt_is_last(r_cnt)) begin
              r_cnt   <= '0;
              r_shift <= '0;
              if (!w_fss) begin
                r_state <= ST_IDLE;
              end
              if (!r_valid || RX_READY) begin
                r_rxdata <= {r_shift, w_rxd};
                r_valid  <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else if (w_fss) begin
              r_frame_err <= 1'b1;
              r_cnt       <= '0;
              r_shift     <= '0;
            end else begin
              r_shift <= {r_shift[SSP_FRAME_W-3:0], w_rxd};
              r_cnt   <= r_cnt + SSP_CNT_W'(1);
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign RXDATA       = r_rxdata;
  assign RX_VALID     = r_valid;
  assign RX_BUSY      = (r_state == ST_SHIFT);
  assign RX_OVERRUN   = r_overrun;
  assign RX_FRAME_ERR = r_frame_err;

endmodule
